// File: rtl/ex2_pkg.sv
// rtl/ex2_pkg.sv - shared widths and limits for the E[x^2] second-moment unit
// Purpose : one place for the datapath widths used by ex2_unit and ex2_square_compress.
// Ports   : none (package).
// Config  : EX2_ROUND_EN (consumed in ex2_unit) selects round-half-up for the final scale.
package ex2_pkg;

  localparam int N_ELEMS  = 16;
  localparam int X_W      = 9;
  localparam int SQ_W     = 17;
  localparam int ACC_W    = 21;
  localparam int INV_W    = 8;
  localparam int INV_FRAC = 9;
  localparam int OUT_W    = 8;
  localparam int OUT_MAX  = 255;
  localparam int CNT_W    = $clog2(N_ELEMS);
  // One spare bit above ACC_W+INV_W so the rounding increment cannot wrap.
  localparam int PROD_W   = ACC_W + INV_W + 1;

endpackage

// File: rtl/ex2_square_compress.sv
// rtl/ex2_square_compress.sv - combinational x*x followed by a 2*alpha right shift
// Purpose : square one signed sample and apply dynamic compression.
// Ports   : i_x     [X_W-1:0]  signed two's complement sample
//           i_alpha [1:0]      compression shift, square is shifted right by 2*alpha
//           o_sq    [SQ_W-1:0] unsigned compressed square
module ex2_square_compress
  import ex2_pkg::*;
(
  input  logic [X_W-1:0]  i_x,
  input  logic [1:0]      i_alpha,
  output logic [SQ_W-1:0] o_sq
);

  logic [X_W-1:0]  w_abs;
  logic [SQ_W-1:0] w_sq;

  // |x| fits X_W unsigned bits even for the most negative input (-256 -> 256).
  assign w_abs = i_x[X_W-1] ? ((~i_x) + X_W'(1)) : i_x;
  // Largest square is 256*256 = 2^16, so SQ_W bits hold it without loss.
  assign w_sq  = SQ_W'(w_abs) * SQ_W'(w_abs);
  assign o_sq  = w_sq >> {i_alpha, 1'b0};

endmodule

// File: rtl/ex2_unit.sv
// rtl/ex2_unit.sv - streaming E[x^2] unit: square/compress, accumulate N samples, scale by 1/N
// Purpose : three-stage pipeline producing a saturated 8-bit mean of compressed squares.
// Ports   : i_clk              clock, rising edge
//           i_rstn             synchronous reset, active high (1 = reset)
//           i_valid            i_x carries a sample this cycle
//           i_x     [X_W-1:0]  signed sample
//           i_alpha [1:0]      compression shift (constant within a vector)
//           i_inv_n [INV_W-1:0] reciprocal of N, unsigned Q0.INV_FRAC, used at the output stage
//           o_Ex2_done         one-cycle pulse when o_Ex2 updates
//           o_Ex2   [OUT_W-1:0] result, held until the next done
// Config  : `define EX2_ROUND_EN for round-half-up before saturation; default truncates.
module ex2_unit
  import ex2_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_valid,
  input  logic [X_W-1:0]   i_x,
  input  logic [1:0]       i_alpha,
  input  logic [INV_W-1:0] i_inv_n,
  output logic             o_Ex2_done,
  output logic [OUT_W-1:0] o_Ex2
);

  logic [SQ_W-1:0]   w_sq;
  logic [SQ_W-1:0]   r_sq;
  logic              r_sq_v;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  w_acc_next;
  logic [ACC_W-1:0]  r_acc_fin;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_fin;
  logic [PROD_W-1:0] w_prod;
  logic [PROD_W-1:0] w_prod_rnd;
  logic [PROD_W-1:0] w_r;
  logic              w_sat;
  logic [OUT_W-1:0]  r_ex2;
  logic              r_done;

  ex2_square_compress u_sq (
    .i_x     (i_x),
    .i_alpha (i_alpha),
    .o_sq    (w_sq)
  );

  // Stage 1: register the compressed square; i_x/i_alpha are ignored when not valid.
  always_ff @(posedge i_clk) begin
    if (i_rstn) begin
      r_sq_v <= 1'b0;
      r_sq   <= '0;
    end else begin
      r_sq_v <= i_valid;
      if (i_valid) begin
        r_sq <= w_sq;
      end
    end
  end

  // Stage 2: accumulate. The final sum is handed off to r_acc_fin while r_acc
  // restarts at zero, so a new vector can follow with no bubble.
  assign w_acc_next = r_acc + ACC_W'(r_sq);

  always_ff @(posedge i_clk) begin
    if (i_rstn) begin
      r_acc     <= '0;
      r_acc_fin <= '0;
      r_cnt     <= '0;
      r_fin     <= 1'b0;
    end else begin
      r_fin <= 1'b0;
      if (r_sq_v) begin
        if (r_cnt == CNT_W'(N_ELEMS - 1)) begin
          r_fin     <= 1'b1;
          r_acc_fin <= w_acc_next;
          r_acc     <= '0;
          r_cnt     <= '0;
        end else begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Stage 3: scale by 1/N in fixed point and saturate to OUT_W bits.
  assign w_prod = PROD_W'(r_acc_fin) * PROD_W'(i_inv_n);
`ifdef EX2_ROUND_EN
  assign w_prod_rnd = w_prod + PROD_W'(1 << (INV_FRAC - 1));
`else
  assign w_prod_rnd = w_prod;
`endif
  assign w_r   = w_prod_rnd >> INV_FRAC;
  assign w_sat = (w_r > PROD_W'(OUT_MAX));

  always_ff @(posedge i_clk) begin
    if (i_rstn) begin
      r_ex2  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= r_fin;
      if (r_fin) begin
        r_ex2 <= w_sat ? OUT_W'(OUT_MAX) : w_r[OUT_W-1:0];
      end
    end
  end

  assign o_Ex2      = r_ex2;
  assign o_Ex2_done = r_done;

endmodule

// File: tb/tb_ex2_unit.sv
// tb/tb_ex2_unit.sv - self-checking bench for ex2_unit against a behavioural E[x^2] model
module tb_ex2_unit;

  typedef int vec_t[16];

  logic       i_clk = 1'b0;
  logic       i_rstn;
  logic       i_valid;
  logic [8:0] i_x;
  logic [1:0] i_alpha;
  logic [7:0] i_inv_n;
  logic       o_Ex2_done;
  logic [7:0] o_Ex2;

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  ex2_unit dut (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_valid    (i_valid),
    .i_x        (i_x),
    .i_alpha    (i_alpha),
    .i_inv_n    (i_inv_n),
    .o_Ex2_done (o_Ex2_done),
    .o_Ex2      (o_Ex2)
  );

  // Reference: mean of compressed squares in plain integer arithmetic.
  function automatic int model_ex2(input vec_t xs, input int a, input int inv);
    longint sum;
    longint p;
    sum = 0;
    for (int k = 0; k < 16; k++) sum += longint'((xs[k] * xs[k]) / (1 << (2 * a)));
    p = sum * inv;
`ifdef EX2_ROUND_EN
    p = p + 256;
`endif
    p = p / 512;
    if (p > 255) p = 255;
    return int'(p);
  endfunction

  // Streams one vector; gap_mode 0 = none, 1 = every other cycle idle, 2 = random idles.
  task automatic run_vec(input vec_t xs, input int a, input int inv, input int gap_mode,
                         output int n_done, output int val, output int lat);
    int  i;
    int  cyc;
    int  last;
    bit  gap;
    i = 0; cyc = 0; last = -1; n_done = 0; val = -1; lat = -1;
    while (cyc < 200) begin
      case (gap_mode)
        1:       gap = (cyc % 2) == 1;
        2:       gap = ($urandom_range(0, 2) == 0);
        default: gap = 1'b0;
      endcase
      if (i < 16 && !gap) begin
        i_valid = 1'b1;
        i_x     = xs[i][8:0];
        i_alpha = a[1:0];
      end else begin
        i_valid = 1'b0;
        i_x     = 9'($urandom);
        i_alpha = 2'($urandom);
      end
      i_inv_n = inv[7:0];
      @(posedge i_clk); #1;
      cyc++;
      if (i_valid) begin
        i++;
        if (i == 16) last = cyc;
      end
      if (o_Ex2_done === 1'b1) begin
        n_done++;
        val = int'(o_Ex2);
        lat = (last < 0) ? -1 : cyc - last;
      end
      if (last >= 0 && cyc - last >= 4) break;
    end
    i_valid = 1'b0;
  endtask

  task automatic test_reset();
    i_rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      i_valid = 1'b1;
      i_x     = 9'($urandom);
      i_alpha = 2'($urandom);
      @(posedge i_clk); #1;
      checks++;
      if (o_Ex2 !== 8'd0) begin
        errors++; $display("FAIL reset_ex2 cycle %0d got=%0d exp=0", c, o_Ex2);
      end
      checks++;
      if (o_Ex2_done !== 1'b0) begin
        errors++; $display("FAIL reset_done cycle %0d got=%b exp=0", c, o_Ex2_done);
      end
    end
    i_valid = 1'b0;
    i_rstn  = 1'b0;
  endtask

  task automatic test_known();
    vec_t xs;
    int   n, v, l, exp_v;
    string nm;
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 16; k++) xs[k] = (t == 2) ? -16 : k + 1;
`ifdef EX2_ROUND_EN
      exp_v = (t == 0) ? 6 : (t == 1) ? 94 : 255;
`else
      exp_v = (t == 0) ? 5 : (t == 1) ? 93 : 255;
`endif
      nm = (t == 0) ? "alpha2_ramp" : (t == 1) ? "alpha0_ramp" : "saturate";
      run_vec(xs, (t == 0) ? 2 : 0, 32, 0, n, v, l);
      checks++;
      if (n !== 1) begin errors++; $display("FAIL %s done_count got=%0d exp=1", nm, n); end
      checks++;
      if (l !== 2) begin errors++; $display("FAIL %s latency got=%0d exp=2", nm, l); end
      checks++;
      if (v !== exp_v) begin errors++; $display("FAIL %s value got=%0d exp=%0d", nm, v, exp_v); end
      checks++;
      if (o_Ex2 !== 8'(exp_v)) begin
        errors++; $display("FAIL %s hold got=%0d exp=%0d", nm, o_Ex2, exp_v);
      end
    end
  endtask

  task automatic test_gaps();
    vec_t xs;
    int   n, v, l, exp_v;
    for (int k = 0; k < 16; k++) xs[k] = k + 1;
`ifdef EX2_ROUND_EN
    exp_v = 6;
`else
    exp_v = 5;
`endif
    run_vec(xs, 2, 32, 1, n, v, l);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL gaps done_count got=%0d exp=1", n); end
    checks++;
    if (l !== 2) begin errors++; $display("FAIL gaps latency got=%0d exp=2", l); end
    checks++;
    if (v !== exp_v) begin errors++; $display("FAIL gaps value got=%0d exp=%0d", v, exp_v); end
  endtask

  task automatic test_back_to_back();
    vec_t a_v, b_v;
    int   a1, a2, inv, nd;
    int   dcyc[2];
    int   dval[2];
    a1 = $urandom_range(0, 3); a2 = $urandom_range(0, 3); inv = $urandom_range(1, 255);
    for (int k = 0; k < 16; k++) begin
      a_v[k] = $urandom_range(0, 511) - 256;
      b_v[k] = $urandom_range(0, 511) - 256;
    end
    nd = 0; dcyc[0] = -1; dcyc[1] = -1; dval[0] = -1; dval[1] = -1;
    i_inv_n = inv[7:0];
    for (int c = 0; c < 40; c++) begin
      if (c < 32) begin
        i_valid = 1'b1;
        i_x     = (c < 16) ? a_v[c][8:0] : b_v[c-16][8:0];
        i_alpha = (c < 16) ? a1[1:0] : a2[1:0];
      end else begin
        i_valid = 1'b0;
      end
      @(posedge i_clk); #1;
      if (o_Ex2_done === 1'b1) begin
        if (nd < 2) begin dcyc[nd] = c + 1; dval[nd] = int'(o_Ex2); end
        nd++;
      end
    end
    i_valid = 1'b0;
    checks++;
    if (nd !== 2) begin errors++; $display("FAIL b2b done_count got=%0d exp=2", nd); end
    checks++;
    if (dcyc[0] !== 18) begin errors++; $display("FAIL b2b first_done_cycle got=%0d exp=18", dcyc[0]); end
    checks++;
    if (dcyc[1] - dcyc[0] !== 16) begin
      errors++; $display("FAIL b2b spacing got=%0d exp=16", dcyc[1] - dcyc[0]);
    end
    checks++;
    if (dval[0] !== model_ex2(a_v, a1, inv)) begin
      errors++; $display("FAIL b2b value0 got=%0d exp=%0d", dval[0], model_ex2(a_v, a1, inv));
    end
    checks++;
    if (dval[1] !== model_ex2(b_v, a2, inv)) begin
      errors++; $display("FAIL b2b value1 got=%0d exp=%0d", dval[1], model_ex2(b_v, a2, inv));
    end
  endtask

  task automatic test_reset_abort();
    vec_t xs;
    int   n, v, l, exp_v;
    i_inv_n = 8'd32;
    for (int k = 0; k < 8; k++) begin
      i_valid = 1'b1; i_x = 9'd200; i_alpha = 2'd0;
      @(posedge i_clk); #1;
    end
    i_rstn  = 1'b1;
    i_valid = 1'b1; i_x = 9'd200;
    @(posedge i_clk); #1;
    checks++;
    if (o_Ex2 !== 8'd0) begin errors++; $display("FAIL abort_reset_ex2 got=%0d exp=0", o_Ex2); end
    checks++;
    if (o_Ex2_done !== 1'b0) begin errors++; $display("FAIL abort_reset_done got=%b exp=0", o_Ex2_done); end
    i_rstn  = 1'b0;
    i_valid = 1'b0;
    for (int k = 0; k < 16; k++) xs[k] = k + 1;
`ifdef EX2_ROUND_EN
    exp_v = 94;
`else
    exp_v = 93;
`endif
    run_vec(xs, 0, 32, 0, n, v, l);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL abort done_count got=%0d exp=1", n); end
    checks++;
    if (l !== 2) begin errors++; $display("FAIL abort latency got=%0d exp=2", l); end
    checks++;
    if (v !== exp_v) begin errors++; $display("FAIL abort value got=%0d exp=%0d", v, exp_v); end
  endtask

  task automatic test_random();
    vec_t xs;
    int   a, inv, n, v, l, exp_v;
    for (int t = 0; t < 8; t++) begin
      a   = $urandom_range(0, 3);
      inv = $urandom_range(0, 255);
      for (int k = 0; k < 16; k++) xs[k] = $urandom_range(0, 511) - 256;
      exp_v = model_ex2(xs, a, inv);
      run_vec(xs, a, inv, 2, n, v, l);
      checks++;
      if (n !== 1) begin errors++; $display("FAIL rand%0d done_count got=%0d exp=1", t, n); end
      checks++;
      if (l !== 2) begin errors++; $display("FAIL rand%0d latency got=%0d exp=2", t, l); end
      checks++;
      if (v !== exp_v) begin errors++; $display("FAIL rand%0d value got=%0d exp=%0d", t, v, exp_v); end
    end
  endtask

  initial begin
    i_rstn  = 1'b1;
    i_valid = 1'b0;
    i_x     = '0;
    i_alpha = '0;
    i_inv_n = 8'd32;
    test_reset();
    test_known();
    test_gaps();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1);
  end

endmodule
